// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// ALU-control classes and the bundled control word driven by control_fsm.
package control_fsm_pkg;

  localparam logic [3:0] OP_RTYPE  = 4'd0;
  localparam logic [3:0] OP_SHIFTI = 4'd1;
  localparam logic [3:0] OP_ADDI   = 4'd2;
  localparam logic [3:0] OP_LW     = 4'd3;
  localparam logic [3:0] OP_SW     = 4'd4;
  localparam logic [3:0] OP_BEQ    = 4'd5;
  localparam logic [3:0] OP_J      = 4'd6;
  localparam logic [3:0] OP_SLTI   = 4'd7;

  // ALU_Control decodes these same class values.
  localparam logic [2:0] ALU_FUNCT = 3'd0;
  localparam logic [2:0] ALU_SHIFT = 3'd1;
  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd7;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_ONE   = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_SHIMM = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // FETCH is zero so the debug state port reads 0 while reset is held.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_EXEC_SLTI = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_RD    = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WR    = 4'd8,
    S_ALU_WB_R  = 4'd9,
    S_ALU_WB_I  = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       reg_dst;
    logic       halted;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/control_fsm.sv
// Multicycle datapath controller: Moore FSM stepping FETCH/DECODE/execute
// phases, with EXEC_I's ALUOp as the one opcode-dependent output.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  output logic [2:0] ALUOp,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       RegDst,
  output logic       halted,
  output logic [3:0] state
);

  state_t state_q;
  state_t next_state;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    ctrl       = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_ALU;
        next_state     = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIMM;
        ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:         next_state = S_EXEC_R;
          OP_SHIFTI,
          OP_ADDI:          next_state = S_EXEC_I;
          OP_SLTI:          next_state = S_EXEC_SLTI;
          OP_LW, OP_SW:     next_state = S_MEM_ADDR;
          OP_BEQ:           next_state = S_BRANCH;
          OP_J:             next_state = S_JUMP;
          default:          next_state = S_HALT;
        endcase
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        next_state     = S_ALU_WB_R;
      end
      S_EXEC_I: begin
        // Opcode is stable in the IR here, so this tap does not glitch.
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_SHIFTI) ? ALU_SHIFT : ALU_ADD;
        next_state     = S_ALU_WB_I;
      end
      S_EXEC_SLTI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_SLT;
        next_state     = S_ALU_WB_I;
      end
      S_ALU_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        next_state     = S_FETCH;
      end
      S_ALU_WB_I: begin
        ctrl.reg_write = 1'b1;
        next_state     = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        next_state     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        next_state    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        next_state      = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        next_state     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        next_state         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        next_state     = S_FETCH;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
        next_state  = S_HALT;
      end
      default: begin
        ctrl       = '0;
        next_state = S_FETCH;
      end
    endcase
  end

  // Reset masks the control word so FETCH's enables stay quiet until release.
  assign ctrl_out    = reset_n ? ctrl : '0;
  assign ALUOp       = ctrl_out.alu_op;
  assign PCWrite     = ctrl_out.pc_write;
  assign PCWriteCond = ctrl_out.pc_write_cond;
  assign IorD        = ctrl_out.iord;
  assign MemRead     = ctrl_out.mem_read;
  assign MemWrite    = ctrl_out.mem_write;
  assign IRWrite     = ctrl_out.ir_write;
  assign MemtoReg    = ctrl_out.mem_to_reg;
  assign RegWrite    = ctrl_out.reg_write;
  assign ALUSrcA     = ctrl_out.alu_src_a;
  assign ALUSrcB     = ctrl_out.alu_src_b;
  assign PCSource    = ctrl_out.pc_source;
  assign RegDst      = ctrl_out.reg_dst;
  assign halted      = ctrl_out.halted;
  assign state       = state_q;

endmodule
